// File: rtl/peri_bus_arbiter.sv
// rtl/peri_bus_arbiter.sv - two-host peripheral bus arbiter with in-order response routing
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   hN_req/addr/write/be/wdata      host N request (N=0 core, N=1 secondary master)
//   hN_gnt, hN_rvalid, hN_rdata     grant, response valid and response data to host N
//   peri_req/addr/write/be/wdata    device-side request
//   peri_gnt, peri_rvalid, peri_rdata  device-side grant and response
//   resp_err                        one-cycle pulse on peri_rvalid with nothing outstanding
//
// Configuration:
//   PERI_ARB_RR_EN  defined -> round-robin between hosts on ties
//                   undefined -> fixed priority, host 0 wins ties
module peri_bus_arbiter #(
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h0_req,
    input  logic [31:0] h0_addr,
    input  logic        h0_write,
    input  logic [3:0]  h0_be,
    input  logic [31:0] h0_wdata,
    output logic        h0_gnt,
    output logic        h0_rvalid,
    output logic [31:0] h0_rdata,
    input  logic        h1_req,
    input  logic [31:0] h1_addr,
    input  logic        h1_write,
    input  logic [3:0]  h1_be,
    input  logic [31:0] h1_wdata,
    output logic        h1_gnt,
    output logic        h1_rvalid,
    output logic [31:0] h1_rdata,
    output logic        peri_req,
    output logic [31:0] peri_addr,
    output logic        peri_write,
    output logic [3:0]  peri_be,
    output logic [31:0] peri_wdata,
    input  logic        peri_gnt,
    input  logic        peri_rvalid,
    input  logic [31:0] peri_rdata,
    output logic        resp_err
);

    // ID FIFO is sized for the largest legal MAX_OUTST; only the first
    // MAX_OUTST entries are used because the pointers wrap at MAX_OUTST.
    logic [3:0] id_fifo;
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       locked;
    logic       lock_sel;
    logic       prio;
    logic       sel;
    logic       lock_active;
    logic       full;
    logic       empty;
    logic       grant;
    logic       pop;
    logic       head;

    assign full  = (count == 3'(MAX_OUTST));
    assign empty = (count == 3'd0);

`ifdef PERI_ARB_RR_EN
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (grant) begin
            rr_ptr <= ~sel;
        end
    end

    assign prio = rr_ptr;
`else
    assign prio = 1'b0;
`endif

    // A lock only matters while the locked host still asserts its request.
    assign lock_active = locked & (lock_sel ? h1_req : h0_req);

    always_comb begin
        sel = 1'b0;
        if (lock_active) begin
            sel = lock_sel;
        end else if (h0_req && h1_req) begin
            sel = prio;
        end else begin
            sel = h1_req & ~h0_req;
        end
    end

    assign peri_req = (h0_req | h1_req) & ~full & rst_n;
    assign grant    = peri_req & peri_gnt;
    assign h0_gnt   = grant & ~sel;
    assign h1_gnt   = grant & sel;

    always_comb begin
        peri_addr  = 32'd0;
        peri_write = 1'b0;
        peri_be    = 4'd0;
        peri_wdata = 32'd0;
        if (peri_req) begin
            peri_addr  = sel ? h1_addr  : h0_addr;
            peri_write = sel ? h1_write : h0_write;
            peri_be    = sel ? h1_be    : h0_be;
            peri_wdata = sel ? h1_wdata : h0_wdata;
        end
    end

    assign head      = id_fifo[rd_ptr];
    assign pop       = peri_rvalid & ~empty & rst_n;
    assign h0_rvalid = pop & ~head;
    assign h1_rvalid = pop & head;
    assign h0_rdata  = peri_rdata;
    assign h1_rdata  = peri_rdata;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(MAX_OUTST - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_fifo  <= 4'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            locked   <= 1'b0;
            lock_sel <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            resp_err <= peri_rvalid & empty;
            if (grant) begin
                id_fifo[wr_ptr] <= sel;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({grant, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            // A stalled request pins sel so its address phase cannot change.
            if (peri_req && !peri_gnt) begin
                locked   <= 1'b1;
                lock_sel <= sel;
            end else if (grant) begin
                locked <= 1'b0;
            end
        end
    end

endmodule
